// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  lsu_pkg
//  Shared access-width codes, FSM state encoding and byte-enable patterns
//  for the load/store unit.
//  Revision: 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] MEM_WIDTH_WORD = 2'b00;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
    localparam logic [1:0] MEM_WIDTH_BYTE = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_t;

    // Patterns for offset 0; shifted left by the byte offset.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/load_aligner.sv
`default_nettype none
// ============================================================================
//  load_aligner
//  Shifts bus read data down by the byte offset and sign/zero-extends it.
//  Revision: 1.0
// ============================================================================
module load_aligner
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic        load_signed,
    output logic [31:0] data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = rdata >> {offset, 3'b000};
        case (width)
            MEM_WIDTH_BYTE: data = {{24{load_signed & w_shifted[7]}},  w_shifted[7:0]};
            MEM_WIDTH_HALF: data = {{16{load_signed & w_shifted[15]}}, w_shifted[15:0]};
            default:        data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  load_store_unit
//  Turns byte/half/word loads and stores into aligned 32-bit bus accesses,
//  stalling until acknowledge or timeout. Option: LSU_MISALIGN_TRAP_EN.
//  Revision: 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_bus_read,
    input  logic        cs_bus_write,
    input  logic [1:0]  cs_mem_width,
    input  logic        cs_load_signed,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        bus_error,
    output logic        misaligned,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_re,
    output logic        bus_we,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam logic [7:0] c_last_count = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state, w_state_next;
    logic [7:0]  r_count;
    logic [1:0]  r_offset, r_width;
    logic        r_signed, r_is_write;
    logic [31:0] r_bus_addr, r_bus_wdata, r_load_data;
    logic [3:0]  r_bus_be;
    logic        r_bus_error, r_misaligned;

    logic        w_req, w_conflict, w_trap, w_accept, w_timeout;
    logic [1:0]  w_width, w_offset;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_extracted;

    assign w_req      = cs_bus_read | cs_bus_write;
    assign w_conflict = cs_bus_read & cs_bus_write;
    assign w_width    = (cs_mem_width == 2'b11) ? MEM_WIDTH_WORD : cs_mem_width;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = w_req & ~w_conflict &
                    (((w_width == MEM_WIDTH_HALF) & addr[0]) |
                     ((w_width == MEM_WIDTH_WORD) & (addr[1:0] != 2'b00)));
`else
    assign w_trap = 1'b0;
`endif

    assign w_accept  = (r_state == LSU_IDLE) & w_req & ~w_conflict & ~w_trap;
    assign w_timeout = (r_state == LSU_ACCESS) & ~bus_ready & (r_count == c_last_count);

    // Misaligned requests that reach here are forced onto their natural boundary.
    always_comb begin
        case (w_width)
            MEM_WIDTH_BYTE: begin
                w_offset = addr[1:0];
                w_be     = BE_BYTE << addr[1:0];
                w_wdata  = {4{store_data[7:0]}};
            end
            MEM_WIDTH_HALF: begin
                w_offset = {addr[1], 1'b0};
                w_be     = BE_HALF << {addr[1], 1'b0};
                w_wdata  = {2{store_data[15:0]}};
            end
            default: begin
                w_offset = 2'b00;
                w_be     = BE_WORD;
                w_wdata  = store_data;
            end
        endcase
    end

    load_aligner u_load_aligner (
        .rdata       (bus_rdata),
        .offset      (r_offset),
        .width       (r_width),
        .load_signed (r_signed),
        .data        (w_extracted)
    );

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (w_accept) begin
                    w_state_next = LSU_ACCESS;
                    stall        = 1'b1;
                end
            end
            LSU_ACCESS: begin
                stall = 1'b1;
                if (bus_ready || w_timeout) w_state_next = LSU_DONE;
            end
            LSU_DONE: w_state_next = LSU_IDLE;
            default:  w_state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LSU_IDLE;
            r_count      <= 8'd0;
            r_offset     <= 2'b00;
            r_width      <= MEM_WIDTH_WORD;
            r_signed     <= 1'b0;
            r_is_write   <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_wdata  <= 32'd0;
            r_bus_be     <= 4'd0;
            r_load_data  <= 32'd0;
            r_bus_error  <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bus_error  <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_req && w_conflict) begin
                        r_bus_error <= 1'b1;
                    end else if (w_trap) begin
                        r_misaligned <= 1'b1;
                        if (cs_bus_read) r_load_data <= 32'd0;
                    end else if (w_accept) begin
                        r_count     <= 8'd0;
                        r_offset    <= w_offset;
                        r_width     <= w_width;
                        r_signed    <= cs_load_signed;
                        r_is_write  <= cs_bus_write;
                        r_bus_addr  <= {addr[31:2], 2'b00};
                        r_bus_wdata <= w_wdata;
                        r_bus_be    <= w_be;
                    end
                end
                LSU_ACCESS: begin
                    if (bus_ready) begin
                        if (!r_is_write) r_load_data <= w_extracted;
                    end else if (w_timeout) begin
                        r_load_data <= 32'd0;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_re     = (r_state == LSU_ACCESS) & ~r_is_write;
    assign bus_we     = (r_state == LSU_ACCESS) &  r_is_write;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_be     = r_bus_be;
    assign load_data  = r_load_data;
    assign bus_error  = r_bus_error;
    assign misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  tb_load_store_unit
//  Directed and randomized transactions checked against a byte-level model.
//  Revision: 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_bus_read = 1'b0, cs_bus_write = 1'b0, cs_load_signed = 1'b0;
    logic [1:0]  cs_mem_width = 2'b00;
    logic [31:0] addr = 32'd0, store_data = 32'd0, bus_rdata = 32'd0;
    logic        bus_ready = 1'b0;
    logic        stall, bus_error, misaligned, bus_re, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .cs_bus_read(cs_bus_read), .cs_bus_write(cs_bus_write),
        .cs_mem_width(cs_mem_width), .cs_load_signed(cs_load_signed),
        .addr(addr), .store_data(store_data),
        .stall(stall), .load_data(load_data), .bus_error(bus_error),
        .misaligned(misaligned), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_re(bus_re), .bus_we(bus_we),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes_of(input logic [1:0] w);
        return (w == 2'b10) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic int offset_of(input logic [1:0] w, input logic [31:0] a);
        int n = nbytes_of(w);
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic bit is_trap(input logic [1:0] w, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % nbytes_of(w)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] w, input logic sgn,
                                               input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes_of(w);
        longint v = longint'(rd) >> (8 * offset_of(w, a));
        longint span = longint'(1) << (8 * n);
        v = v % span;
        if (sgn && n < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] w, input logic [31:0] a);
        int be = ((1 << nbytes_of(w)) - 1) << offset_of(w, a);
        return be[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] sd);
        logic [31:0] r;
        int n = nbytes_of(w);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
        return r;
    endfunction

    // Called just after a rising edge with the unit idle. delay = ACCESS cycle
    // in which ready is raised; 0 means never.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [1:0] w, input logic sgn, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rdat, input int delay);
        bit conflict = rd && wr;
        bit trap     = !conflict && is_trap(w, a);
        bit timed_out = !(delay >= 1 && delay <= TMO);
        bit fin = 1'b0;
        int c = 1;
        cs_bus_read = rd; cs_bus_write = wr; cs_mem_width = w; cs_load_signed = sgn;
        addr = a; store_data = sd; bus_ready = 1'($urandom % 2); bus_rdata = $urandom;
        @(negedge clk);
        check({tag, ".req_stall"}, 32'(stall), 32'(!(conflict || trap)));
        next_cycle();
        if (conflict || trap) begin
            cs_bus_read = 1'b0; cs_bus_write = 1'b0;
            @(negedge clk);
            check({tag, ".err_pulse"}, 32'(bus_error), 32'(conflict));
            check({tag, ".mis_pulse"}, 32'(misaligned), 32'(trap));
            check({tag, ".no_strobe"}, {30'd0, bus_re, bus_we}, 32'd0);
            check({tag, ".no_stall"}, 32'(stall), 32'd0);
            if (trap && rd) check({tag, ".trap_ld"}, load_data, 32'd0);
            next_cycle();
            @(negedge clk);
            check({tag, ".pulse_end"}, {30'd0, bus_error, misaligned}, 32'd0);
            next_cycle();
            return;
        end
        while (!fin) begin
            bus_ready = (c == delay);
            bus_rdata = (c == delay) ? rdat : $urandom;
            @(negedge clk);
            check($sformatf("%s.acc%0d_stall", tag, c), 32'(stall), 32'd1);
            check($sformatf("%s.acc%0d_strobe", tag, c), {30'd0, bus_re, bus_we}, {30'd0, !wr, wr});
            check($sformatf("%s.acc%0d_addr", tag, c), bus_addr, a & 32'hFFFF_FFFC);
            check($sformatf("%s.acc%0d_be", tag, c), 32'(bus_be), 32'(model_be(w, a)));
            if (wr) check($sformatf("%s.acc%0d_wdata", tag, c), bus_wdata, model_wdata(w, sd));
            if (c == delay || c == TMO) fin = 1'b1;
            c++;
            next_cycle();
        end
        bus_ready = 1'($urandom % 2); bus_rdata = $urandom;
        @(negedge clk);
        check({tag, ".done_stall"}, 32'(stall), 32'd0);
        check({tag, ".done_strobe"}, {30'd0, bus_re, bus_we}, 32'd0);
        check({tag, ".done_err"}, 32'(bus_error), 32'(timed_out));
        if (rd || timed_out)
            check({tag, ".load_data"}, load_data, timed_out ? 32'd0 : model_load(w, sgn, a, rdat));
        next_cycle();
        cs_bus_read = 1'b0; cs_bus_write = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        check({tag, ".after_err"}, 32'(bus_error), 32'd0);
        check({tag, ".after_stall"}, 32'(stall), 32'd0);
        next_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".stall"}, 32'(stall), 32'd0);
        check({tag, ".load_data"}, load_data, 32'd0);
        check({tag, ".flags"}, {29'd0, bus_error, misaligned, bus_re}, 32'd0);
        check({tag, ".bus_we"}, 32'(bus_we), 32'd0);
        check({tag, ".bus_addr"}, bus_addr, 32'd0);
        check({tag, ".bus_wdata"}, bus_wdata, 32'd0);
        check({tag, ".bus_be"}, 32'(bus_be), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        next_cycle();

        run_txn("lb_signed",  1, 0, 2'b10, 1, 32'h0000_0103, 32'd0, 32'h8012_3456, 1);
        run_txn("lhu",        1, 0, 2'b01, 0, 32'h0000_0202, 32'd0, 32'h9ABC_1234, 1);
        run_txn("sb",         0, 1, 2'b10, 0, 32'h0000_0001, 32'h0000_00A5, 32'd0, 2);
        run_txn("lw_wait3",   1, 0, 2'b00, 0, 32'h0000_0400, 32'd0, 32'hDEAD_BEEF, 3);
        run_txn("lw_timeout", 1, 0, 2'b00, 0, 32'h0000_0400, 32'd0, 32'hDEAD_BEEF, 0);
        run_txn("lw_mis",     1, 0, 2'b00, 0, 32'h0000_0102, 32'd0, 32'h1122_3344, 1);
        run_txn("sh_mis",     0, 1, 2'b01, 0, 32'h0000_0013, 32'h0000_BEEF, 32'd0, 1);
        run_txn("conflict",   1, 1, 2'b00, 0, 32'h0000_0010, 32'h1234_5678, 32'd0, 1);

        // Reset while an access is outstanding.
        cs_bus_read = 1'b1; cs_mem_width = 2'b00; addr = 32'h0000_0300; bus_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rst_mid.in_access", 32'(bus_re), 32'd1);
        #4;
        reset = 1'b1; cs_bus_read = 1'b0;
        next_cycle();
        @(negedge clk);
        check_reset_outputs("rst_mid");
        #4;
        reset = 1'b0;
        next_cycle();
        run_txn("post_rst", 1, 0, 2'b01, 1, 32'h0000_0302, 32'd0, 32'hF00D_0000, 2);

        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom % 16);
            run_txn($sformatf("rnd%0d", i), kind != 0 && kind < 9, kind == 0 || kind >= 9,
                    2'($urandom % 4), 1'($urandom % 2), $urandom, $urandom, $urandom,
                    int'($urandom_range(1, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
